// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle between a master and the SRAM slave.
// Clock and reset stay outside as plain ports of the users.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI slave RAM with independent INCR/FIXED read and write burst engines.
// First rvalid RD_LAT+1 cycles after AR; bresp one cycle after wlast; all outputs held under backpressure.
module axi_sram_slave #(
    parameter int MEM_AW    = 16,
    parameter int RD_LAT    = 2,
    parameter int INIT_ZERO = 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_sram_slave_if.slave  s_axi
);
    localparam logic [31:0] MEM_INIT = (INIT_ZERO != 0) ? 32'h0 : 32'hx;
    localparam logic [7:0]  LAT_INIT = (RD_LAT > 0) ? 8'(RD_LAT - 1) : 8'd0;

    typedef enum logic [1:0] {R_IDLE, R_LAT, R_BEAT} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [31:0] r_mem [0:(1 << MEM_AW) - 1] = '{default: MEM_INIT};

    rstate_t            r_rstate;
    logic               r_arready, r_rvalid, r_rlast, r_rfixed;
    logic [3:0]         r_rid;
    logic [31:0]        r_rdata;
    logic [MEM_AW-1:0]  r_ridx;
    logic [7:0]         r_rlen, r_rcnt, r_rlat;

    wstate_t            r_wstate;
    logic               r_awready, r_wready, r_bvalid, r_wfixed;
    logic [3:0]         r_bid;
    logic [1:0]         r_bresp;
    logic [MEM_AW-1:0]  r_widx;
    logic [7:0]         r_wlen, r_wcnt;

    logic [MEM_AW-1:0]  w_ar_idx, w_aw_idx, w_r_next, w_w_next;
    logic               w_wr_en;
    logic               w_unused;

    // Upper address bits alias; sub-word address bits and sizes carry no meaning here.
    assign w_ar_idx = s_axi.araddr[MEM_AW+1:2];
    assign w_aw_idx = s_axi.awaddr[MEM_AW+1:2];
    assign w_r_next = r_rfixed ? r_ridx : r_ridx + MEM_AW'(1);
    assign w_w_next = r_wfixed ? r_widx : r_widx + MEM_AW'(1);
    assign w_wr_en  = aresetn && (r_wstate == W_DATA) && s_axi.wvalid;
    assign w_unused = ^{s_axi.wid, s_axi.arsize, s_axi.awsize,
                        s_axi.araddr[31:MEM_AW+2], s_axi.araddr[1:0],
                        s_axi.awaddr[31:MEM_AW+2], s_axi.awaddr[1:0]};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= 4'd0;
            r_rdata   <= 32'd0;
        end else begin
            case (r_rstate)
                R_IDLE: if (s_axi.arvalid) begin
                    r_arready <= 1'b0;
                    r_rid     <= s_axi.arid;
                    r_ridx    <= w_ar_idx;
                    r_rlen    <= s_axi.arlen;
                    r_rfixed  <= (s_axi.arburst == 2'b00);
                    r_rcnt    <= 8'd0;
                    r_rlat    <= LAT_INIT;
                    if (RD_LAT == 0) begin
                        r_rdata  <= r_mem[w_ar_idx];
                        r_rvalid <= 1'b1;
                        r_rlast  <= (s_axi.arlen == 8'd0);
                        r_rstate <= R_BEAT;
                    end else begin
                        r_rstate <= R_LAT;
                    end
                end
                R_LAT: if (r_rlat == 8'd0) begin
                    r_rdata  <= r_mem[r_ridx];
                    r_rvalid <= 1'b1;
                    r_rlast  <= (r_rlen == 8'd0);
                    r_rstate <= R_BEAT;
                end else begin
                    r_rlat <= r_rlat - 8'd1;
                end
                R_BEAT: if (s_axi.rready) begin
                    if (r_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end else begin
                        // Prefetch the next word on the accepting edge so beats stream back-to-back.
                        r_ridx  <= w_r_next;
                        r_rcnt  <= r_rcnt + 8'd1;
                        r_rdata <= r_mem[w_r_next];
                        r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= 4'd0;
            r_bresp   <= 2'b00;
        end else begin
            case (r_wstate)
                W_IDLE: if (s_axi.awvalid) begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b1;
                    r_bid     <= s_axi.awid;
                    r_widx    <= w_aw_idx;
                    r_wlen    <= s_axi.awlen;
                    r_wfixed  <= (s_axi.awburst == 2'b00);
                    r_wcnt    <= 8'd0;
                    r_wstate  <= W_DATA;
                end
                W_DATA: if (s_axi.wvalid) begin
                    r_widx <= w_w_next;
                    r_wcnt <= (r_wcnt == 8'hFF) ? r_wcnt : r_wcnt + 8'd1;
                    // Only wlast closes the burst; a short or long burst is flagged, not truncated.
                    if (s_axi.wlast) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= (r_wcnt == r_wlen) ? 2'b00 : 2'b10;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: if (s_axi.bready) begin
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_wstate  <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // A read load on the same edge as this write sees the old word.
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.wstrb[b]) r_mem[r_widx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
        end
    end

    assign s_axi.arready = r_arready;
    assign s_axi.rid     = r_rid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rlast   = r_rlast;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bid     = r_bid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.bvalid  = r_bvalid;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: stimulus pushes expected R/B responses,
// a monitor pops and compares them on every handshake.
module tb_axi_sram_slave;
    logic aclk = 1'b0;
    logic aresetn;

    always #5 aclk = ~aclk;

    axi_sram_slave_if axi();

    axi_sram_slave #(.MEM_AW(16), .RD_LAT(2), .INIT_ZERO(1)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axi   (axi)
    );

    typedef struct packed {logic [3:0] id; logic [31:0] data; logic last;} rexp_t;
    typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

    rexp_t exp_r[$];
    bexp_t exp_b[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic last);
        exp_r.push_back(rexp_t'{id, data, last});
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        exp_b.push_back(bexp_t'{id, resp});
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arburst = burst; axi.arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (axi.arready) begin ok = 1; break; end
        end
        if (!ok) begin n_vec++; n_err++; $display("FAIL ar_timeout: arready never seen for addr 0x%0h", addr); end
        tick();
        axi.arvalid = 1'b0;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awburst = burst; axi.awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (axi.awready) begin ok = 1; break; end
        end
        if (!ok) begin n_vec++; n_err++; $display("FAIL aw_timeout: awready never seen for addr 0x%0h", addr); end
        tick();
        axi.awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok = 0;
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (axi.wready) begin ok = 1; break; end
        end
        if (!ok) begin n_vec++; n_err++; $display("FAIL w_timeout: wready never seen for data 0x%0h", data); end
        tick();
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
    endtask

    task automatic wait_r_empty();
        for (int i = 0; i < 200 && exp_r.size() != 0; i++) @(negedge aclk);
        if (exp_r.size() != 0) begin n_vec++; n_err++; $display("FAIL r_drain: %0d beats outstanding, want 0", exp_r.size()); end
        tick();
    endtask

    task automatic wait_b_empty();
        for (int i = 0; i < 200 && exp_b.size() != 0; i++) @(negedge aclk);
        if (exp_b.size() != 0) begin n_vec++; n_err++; $display("FAIL b_drain: %0d responses outstanding, want 0", exp_b.size()); end
        tick();
    endtask

    // Monitor: scoreboard pops on handshakes plus R stability under stall.
    initial begin : monitor
        bit          stall;
        logic [36:0] held;
        rexp_t       er;
        bexp_t       eb;
        stall = 0;
        held  = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall = 0;
            end else begin
                if (stall && axi.rvalid)
                    check("r_stable", 64'({axi.rid, axi.rdata, axi.rlast}), 64'(held));
                if (axi.rvalid && axi.rready) begin
                    if (exp_r.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL r_unexpected: got id %0h data 0x%0h last %0b, want no beat", axi.rid, axi.rdata, axi.rlast);
                    end else begin
                        er = exp_r.pop_front();
                        check("r_beat", 64'({axi.rid, axi.rdata, axi.rlast}), 64'(er));
                    end
                end
                stall = axi.rvalid && !axi.rready;
                held  = {axi.rid, axi.rdata, axi.rlast};
                if (axi.bvalid && axi.bready) begin
                    if (exp_b.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL b_unexpected: got id %0h resp %0h, want no response", axi.bid, axi.bresp);
                    end else begin
                        eb = exp_b.pop_front();
                        check("b_resp", 64'({axi.bid, axi.bresp}), 64'(eb));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int hs;
        int n_rv;
        int ar_bad;
        aresetn = 1'b0;
        axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 0;
        axi.rready = 1'b1;
        axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 3'd2; axi.awburst = 2'b01; axi.awvalid = 0;
        axi.wid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.wvalid = 0;
        axi.bready = 1'b1;
        repeat (3) tick();
        aresetn = 1'b1;
        @(negedge aclk);
        check("reset_state", 64'({axi.arready, axi.awready, axi.rvalid, axi.wready, axi.bvalid, axi.rlast,
                                  axi.rid, axi.bid, axi.rdata, axi.bresp}),
              64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 2'b00}));
        tick();

        // Single write, bvalid one cycle after the wlast handshake.
        push_b(4'h3, 2'b00);
        do_aw(4'h3, 32'h100, 8'd0, 2'b01);
        do_w(32'hDEADBEEF, 4'hF, 1'b1);
        @(negedge aclk);
        check("b_after_wlast", 64'({axi.bvalid, axi.bid, axi.bresp}), 64'({1'b1, 4'h3, 2'b00}));
        wait_b_empty();

        // Single read, first rvalid 3 cycles after AR handshake.
        axi.rready = 1'b0;
        push_r(4'h7, 32'hDEADBEEF, 1'b1);
        do_ar(4'h7, 32'h100, 8'd0, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            @(negedge aclk);
            check("rd_latency", 64'(axi.rvalid), 64'(k == 3));
        end
        tick();
        axi.rready = 1'b1;
        wait_r_empty();

        // 4-beat INCR write and streaming read.
        push_b(4'h2, 2'b00);
        do_aw(4'h2, 32'h200, 8'd3, 2'b01);
        do_w(32'h11111111, 4'hF, 1'b0);
        do_w(32'h22222222, 4'hF, 1'b0);
        do_w(32'h33333333, 4'hF, 1'b0);
        do_w(32'h44444444, 4'hF, 1'b1);
        wait_b_empty();
        push_r(4'h4, 32'h11111111, 1'b0);
        push_r(4'h4, 32'h22222222, 1'b0);
        push_r(4'h4, 32'h33333333, 1'b0);
        push_r(4'h4, 32'h44444444, 1'b1);
        do_ar(4'h4, 32'h200, 8'd3, 2'b01);
        n_rv = 0; ar_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (axi.arready) ar_bad++;
            if (axi.rvalid) n_rv++;
            if (axi.rvalid && axi.rlast) break;
        end
        check("burst_rvalid_cycles", 64'(n_rv), 64'd4);
        check("burst_arready_low", 64'(ar_bad), 64'd0);
        wait_r_empty();

        // Byte strobes over zeroed word, then FIXED read.
        push_b(4'h1, 2'b00);
        do_aw(4'h1, 32'h0, 8'd0, 2'b01);
        do_w(32'hAABBCCDD, 4'b0101, 1'b1);
        wait_b_empty();
        for (int i = 0; i < 4; i++) push_r(4'h9, 32'h00BB00DD, i == 3);
        do_ar(4'h9, 32'h0, 8'd3, 2'b00);
        wait_r_empty();

        // rready toggling 1,0,0,1 during a 4-beat read.
        push_r(4'h6, 32'h11111111, 1'b0);
        push_r(4'h6, 32'h22222222, 1'b0);
        push_r(4'h6, 32'h33333333, 1'b0);
        push_r(4'h6, 32'h44444444, 1'b1);
        do_ar(4'h6, 32'h200, 8'd3, 2'b01);
        for (int c = 0; c < 200 && exp_r.size() != 0; c++) begin
            axi.rready = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        axi.rready = 1'b1;
        check("bp_read_drained", 64'(exp_r.size()), 64'd0);
        tick();

        // bready held low 5 cycles.
        axi.bready = 1'b0;
        push_b(4'h8, 2'b00);
        do_aw(4'h8, 32'h400, 8'd0, 2'b01);
        do_w(32'h77777777, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bp_bvalid_awready", 64'({axi.bvalid, axi.awready}), 64'(2'b10));
        end
        tick();
        axi.bready = 1'b1;
        wait_b_empty();
        push_r(4'h8, 32'h77777777, 1'b1);
        do_ar(4'h8, 32'h400, 8'd0, 2'b01);
        wait_r_empty();

        // Short burst: awlen=3, wlast on beat 2.
        push_b(4'hA, 2'b10);
        do_aw(4'hA, 32'h300, 8'd3, 2'b01);
        do_w(32'h55555555, 4'hF, 1'b0);
        do_w(32'h66666666, 4'hF, 1'b1);
        wait_b_empty();
        push_r(4'hB, 32'h55555555, 1'b0);
        push_r(4'hB, 32'h66666666, 1'b0);
        push_r(4'hB, 32'h00000000, 1'b1);
        do_ar(4'hB, 32'h300, 8'd2, 2'b01);
        wait_r_empty();

        // Write and rdata load on the same edge: read sees the old word.
        push_b(4'h5, 2'b00);
        do_aw(4'h5, 32'h100, 8'd0, 2'b01);
        push_r(4'hC, 32'hDEADBEEF, 1'b1);
        do_ar(4'hC, 32'h100, 8'd0, 2'b01);
        tick();
        axi.wdata = 32'hCAFEF00D; axi.wstrb = 4'hF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
        @(negedge aclk);
        check("conc_wready", 64'({axi.wready, axi.rvalid}), 64'(2'b10));
        tick();
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        wait_r_empty();
        wait_b_empty();

        // Upper-bit aliasing and INCR wrap at top of memory (burst 10 acts as INCR).
        push_r(4'hD, 32'hCAFEF00D, 1'b1);
        do_ar(4'hD, 32'h1000_0100, 8'd0, 2'b01);
        wait_r_empty();
        push_r(4'hE, 32'h00000000, 1'b0);
        push_r(4'hE, 32'h00BB00DD, 1'b1);
        do_ar(4'hE, 32'h0003_FFFC, 8'd1, 2'b10);
        wait_r_empty();

        // Reset after beat 2 of a 4-beat read.
        push_r(4'hF, 32'h11111111, 1'b0);
        push_r(4'hF, 32'h22222222, 1'b0);
        do_ar(4'hF, 32'h200, 8'd3, 2'b01);
        hs = 0;
        for (int i = 0; i < 50 && hs < 2; i++) begin
            @(negedge aclk);
            if (axi.rvalid && axi.rready) hs++;
        end
        tick();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_mid_outputs", 64'({axi.rvalid, axi.arready, axi.rlast, axi.awready, axi.bvalid}), 64'(5'b01010));
        check("rst_mid_beats", 64'(exp_r.size()), 64'd0);
        tick();
        push_r(4'h1, 32'h11111111, 1'b0);
        push_r(4'h1, 32'h22222222, 1'b0);
        push_r(4'h1, 32'h33333333, 1'b0);
        push_r(4'h1, 32'h44444444, 1'b1);
        do_ar(4'h1, 32'h200, 8'd3, 2'b01);
        wait_r_empty();

        check("final_queues", 64'(exp_r.size() + exp_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
